// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every bus signal around the data-memory arbiter: the core
// LOAD/STORE port, the host/debug port, the single-port memory side and
// the grant indication.
//   slave  : arbiter view (takes requests and mem_rdata, drives acks,
//            read data, memory strobes/address/data and grant)
//   master : environment view (requesters and the memory model)
// Parameters:
//   A_SIZE : address width
//   D_SIZE : data width
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
);
    // core port
    logic              core_req;
    logic              core_we;
    logic [A_SIZE-1:0] core_addr;
    logic [D_SIZE-1:0] core_wdata;
    logic              core_ack;
    logic [D_SIZE-1:0] core_rdata;
    // host port
    logic              host_req;
    logic              host_we;
    logic [A_SIZE-1:0] host_addr;
    logic [D_SIZE-1:0] host_wdata;
    logic              host_ack;
    logic [D_SIZE-1:0] host_rdata;
    // memory side
    logic              mem_read;
    logic              mem_write;
    logic [A_SIZE-1:0] mem_addr;
    logic [D_SIZE-1:0] mem_wdata;
    logic [D_SIZE-1:0] mem_rdata;
    // owner indication: bit0 core, bit1 host
    logic [1:0]        grant;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ack, core_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ack, core_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one single-port synchronous data memory
// (one-cycle read latency) between the core LOAD/STORE port (port 0) and
// the host/debug port (port 1). Each transaction takes four cycles:
//   IDLE (sample/arbitrate) -> ACCESS (strobe) -> CAPTURE (rdata) -> ACK.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mem_arbiter_if.slave (request ports, memory side, grant)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]        state_reg;
    logic              prio_reg;   // port that wins a tie
    logic              owner_reg;  // port owning the transaction in flight
    logic              we_reg;     // latched direction of that transaction
    logic [1:0]        grant_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [A_SIZE-1:0] mem_addr_reg;
    logic [D_SIZE-1:0] mem_wdata_reg;

    // Both request ports viewed as 2-entry arrays indexed by port id.
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [A_SIZE-1:0] addr_vec  [2];
    logic [D_SIZE-1:0] wdata_vec [2];
    logic [1:0]        ack_vec;
    logic [D_SIZE-1:0] rdata_vec [2];
    logic              winner;

    assign req_vec      = {bus.host_req, bus.core_req};
    assign we_vec       = {bus.host_we,  bus.core_we};
    assign addr_vec[0]  = bus.core_addr;
    assign addr_vec[1]  = bus.host_addr;
    assign wdata_vec[0] = bus.core_wdata;
    assign wdata_vec[1] = bus.host_wdata;

    // A lone requester wins outright; on a tie the priority holder wins.
    // With no request the value is unused.
    assign winner = (&req_vec) ? prio_reg : req_vec[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            grant_reg     <= 2'b00;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            // Strobes are single-cycle: only the IDLE->ACCESS edge raises them.
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        // The address/data registers double as the latched
                        // request, so later input changes cannot disturb it.
                        owner_reg     <= winner;
                        we_reg        <= we_vec[winner];
                        mem_addr_reg  <= addr_vec[winner];
                        mem_wdata_reg <= wdata_vec[winner];
                        mem_read_reg  <= ~we_vec[winner];
                        mem_write_reg <= we_vec[winner];
                        grant_reg     <= winner ? 2'b10 : 2'b01;
                        prio_reg      <= ~winner;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS:  state_reg <= CAPTURE;
                CAPTURE: state_reg <= ACK;
                ACK: begin
                    grant_reg <= 2'b00;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port completion: ack and read-data register. Only the owner's
    // registers move, so the other port's rdata is never disturbed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT_ID = 1'(gi);
        logic              ack_reg;
        logic [D_SIZE-1:0] rdata_reg;
        logic              done;

        assign done = (state_reg == CAPTURE) && (owner_reg == PORT_ID);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg <= done;
                if (done && !we_reg) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign bus.core_ack   = ack_vec[0];
    assign bus.host_ack   = ack_vec[1];
    assign bus.core_rdata = rdata_vec[0];
    assign bus.host_rdata = rdata_vec[1];
    assign bus.mem_read   = mem_read_reg;
    assign bus.mem_write  = mem_write_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.grant      = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Random request traffic on both ports against a transaction-level model:
// a timeline of when the arbiter is free, a round-robin tie-break, and a
// reference copy of memory. Each modelled transaction defines the outputs
// expected on its strobe/grant/ack cycles. Includes reset with both
// requests pending and asynchronous resets during a core read's capture.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int A_SIZE   = 10;
    localparam int D_SIZE   = 32;
    localparam int DEPTH    = 1 << A_SIZE;
    localparam int N_CYCLES = 1500;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b0;

    mem_arbiter_if #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) bus ();

    mem_arbiter #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment: single-port synchronous memory, one-cycle read latency.
    logic [D_SIZE-1:0] dev_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < DEPTH; a++) dev_mem[a] <= D_SIZE'(2 * a);
        end else begin
            if (bus.mem_write) dev_mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_read)  bus.mem_rdata <= dev_mem[bus.mem_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [D_SIZE-1:0] ref_mem [DEPTH];
    int                cyc;
    int                free_cycle;     // first cycle the arbiter samples again
    bit                model_prio;
    bit                sched_valid;
    int                sched_start;    // cycle in which the request was taken
    bit                sched_port;
    bit                sched_we;
    logic [A_SIZE-1:0] sched_addr;
    logic [D_SIZE-1:0] sched_wdata;
    logic [D_SIZE-1:0] sched_rval;
    logic [D_SIZE-1:0] exp_rdata [2];
    logic [A_SIZE-1:0] exp_addr;

    // requester state
    bit                pending [2];
    bit                done_q  [2];
    bit                ack_now [2];
    bit                req_we    [2];
    logic [A_SIZE-1:0] req_addr  [2];
    logic [D_SIZE-1:0] req_wdata [2];

    int n_checks = 0;
    int n_errors = 0;
    int n_resets = 0;
    int n_txn    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_ports();
        bus.core_req   = pending[0];
        bus.core_we    = req_we[0];
        bus.core_addr  = req_addr[0];
        bus.core_wdata = req_wdata[0];
        bus.host_req   = pending[1];
        bus.host_we    = req_we[1];
        bus.host_addr  = req_addr[1];
        bus.host_wdata = req_wdata[1];
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"},  64'(bus.grant),      64'd0);
        check_eq({tag, "_cack"},   64'(bus.core_ack),   64'd0);
        check_eq({tag, "_hack"},   64'(bus.host_ack),   64'd0);
        check_eq({tag, "_mread"},  64'(bus.mem_read),   64'd0);
        check_eq({tag, "_mwrite"}, 64'(bus.mem_write),  64'd0);
        check_eq({tag, "_maddr"},  64'(bus.mem_addr),   64'd0);
        check_eq({tag, "_mwdata"}, 64'(bus.mem_wdata),  64'd0);
        check_eq({tag, "_crdata"}, 64'(bus.core_rdata), 64'd0);
        check_eq({tag, "_hrdata"}, 64'(bus.host_rdata), 64'd0);
    endtask

    // Expected outputs for the current cycle from the modelled transaction.
    task automatic check_outputs();
        bit         in_txn, strobe, ack_cyc;
        logic [1:0] exp_grant;
        in_txn  = sched_valid && cyc >= sched_start + 1 && cyc <= sched_start + 3;
        strobe  = sched_valid && cyc == sched_start + 1;
        ack_cyc = sched_valid && cyc == sched_start + 3;
        exp_grant = in_txn ? (sched_port ? 2'b10 : 2'b01) : 2'b00;
        if (strobe) exp_addr = sched_addr;
        if (ack_cyc && !sched_we) exp_rdata[sched_port] = sched_rval;
        ack_now[0] = ack_cyc && !sched_port;
        ack_now[1] = ack_cyc && sched_port;

        check_eq("grant",     64'(bus.grant),     64'(exp_grant));
        check_eq("mem_read",  64'(bus.mem_read),  64'(strobe && !sched_we));
        check_eq("mem_write", 64'(bus.mem_write), 64'(strobe && sched_we));
        check_eq("mem_addr",  64'(bus.mem_addr),  64'(exp_addr));
        if (strobe && sched_we)
            check_eq("mem_wdata", 64'(bus.mem_wdata), 64'(sched_wdata));
        check_eq("core_ack",   64'(bus.core_ack),   64'(ack_now[0]));
        check_eq("host_ack",   64'(bus.host_ack),   64'(ack_now[1]));
        check_eq("core_rdata", 64'(bus.core_rdata), 64'(exp_rdata[0]));
        check_eq("host_rdata", 64'(bus.host_rdata), 64'(exp_rdata[1]));

        if (ack_cyc) begin
            n_txn++;
            $display("txn %0d cyc=%0d port=%s %s addr=%03h data=%08h", n_txn, cyc,
                     sched_port ? "host" : "core", sched_we ? "WR" : "RD", sched_addr,
                     sched_we ? sched_wdata :
                         (sched_port ? bus.host_rdata : bus.core_rdata));
        end
    endtask

    // Requesters: drop after ack is seen, then maybe raise a new request.
    task automatic stimulus();
        int pct;
        pct = (cyc < 400) ? 90 : 35;
        for (int p = 0; p < 2; p++) begin
            if (done_q[p]) pending[p] = 1'b0;
            done_q[p] = ack_now[p];
            if (!pending[p] && !ack_now[p]) begin
                req_we[p]    = $urandom_range(1);
                req_addr[p]  = ($urandom_range(7) == 0) ? A_SIZE'($urandom)
                                                        : A_SIZE'($urandom_range(15));
                req_wdata[p] = $urandom;
                if ($urandom_range(99) < pct) pending[p] = 1'b1;
            end
        end
        drive_ports();
    endtask

    // The arbiter takes a request in any cycle it is free and one is pending.
    task automatic arbitrate();
        bit w;
        if (cyc >= free_cycle && (pending[0] || pending[1])) begin
            w = (pending[0] && pending[1]) ? model_prio : pending[1];
            sched_valid = 1'b1;
            sched_start = cyc;
            sched_port  = w;
            sched_we    = req_we[w];
            sched_addr  = req_addr[w];
            sched_wdata = req_wdata[w];
            if (req_we[w]) ref_mem[req_addr[w]] = req_wdata[w];
            else           sched_rval = ref_mem[req_addr[w]];
            free_cycle  = cyc + 4;
            model_prio  = ~w;
        end
    endtask

    task automatic model_reset();
        sched_valid  = 1'b0;
        model_prio   = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_addr     = '0;
        ack_now[0]   = 1'b0;
        ack_now[1]   = 1'b0;
        done_q[0]    = 1'b0;
        done_q[1]    = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = D_SIZE'(2 * a);
        model_reset();
        // Both ports requesting through reset: core reads 7, host writes 0xD to 1.
        pending[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'd7; req_wdata[0] = '0;
        pending[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 10'd1; req_wdata[1] = 32'hD;
        drive_ports();
        rst = 1'b0;
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        cyc = -3;
        repeat (3) begin
            @(posedge clk); #1;
            check_all_zero("reset");
            cyc++;
        end
        rst = 1'b1;
        cyc = 0;
        free_cycle = 0;
        check_outputs();
        arbitrate();
        while (cyc < N_CYCLES) begin
            @(posedge clk); #1;
            cyc++;
            check_outputs();
            if (sched_valid && !sched_port && !sched_we && cyc == sched_start + 2 &&
                ((n_resets == 0) ? (cyc > 200) : ($urandom_range(29) == 0))) begin
                // Asynchronous reset in the middle of a core read's capture.
                n_resets++;
                rst = 1'b0;
                #1;
                check_all_zero("midrst");
                model_reset();
                @(posedge clk); #1;
                cyc++;
                check_all_zero("midrst_hold");
                rst = 1'b1;
                free_cycle = cyc;
            end
            stimulus();
            arbitrate();
        end
        check_eq("mid_resets_done", 64'(n_resets > 0), 64'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the RISC core's single-port synchronous data memory between the core's LOAD/STORE port and a host/debug port. It serialises requests, drives the one-cycle-latency memory, and returns a registered acknowledge plus read data to the winning requester. It sits between the core, the host interface and the data memory instance.

## Interface
- A_SIZE, 10, address width (matches core)
- D_SIZE, 32, data width (matches core)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- core_req  in  1  core request, level, held until core_ack
- core_we  in  1  1 = write, 0 = read; stable while core_req
- core_addr  in  A_SIZE  core address; stable while core_req
- core_wdata  in  D_SIZE  core write data; stable while core_req
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  D_SIZE  read data, valid with core_ack, held until next core read completes
- host_req, host_we, host_addr, host_wdata, host_ack, host_rdata: same as core_* for the host port
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  A_SIZE  memory address
- mem_wdata  out  D_SIZE  memory write data
- mem_rdata  in  D_SIZE  memory read data, valid the cycle after mem_read
- grant  out  2  one-hot owner: bit0 core, bit1 host; 0 when idle

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE: if any req high, pick winner, latch its we/addr/wdata and port id, set grant, go ACCESS; else stay.
- Arbitration: round-robin pointer prio (0 = core, 1 = host). Only one requester -> it wins. Both -> prio holder wins. After a grant to port N, prio := other port. Reset prio = 0 (core).
- ACCESS: mem_read = !we, mem_write = we for exactly this cycle; mem_addr/mem_wdata from latched values; go CAPTURE.
- CAPTURE: memory returns mem_rdata; for reads, latch into winner's rdata register at end of cycle; writes leave rdata untouched; go ACK.
- ACK: winner's ack = 1 for this cycle only; grant still set; go IDLE. Loser's req stays pending.
- Requester must drop req (or present a new, independent request) at the clock edge ending its ACK cycle. Arbiter ignores req during ACCESS/CAPTURE/ACK; inputs are only sampled in IDLE.
- Request changes during ACCESS..ACK do not affect the transaction in flight (latched copy used).
- Other port's rdata is never modified by a transaction it did not win.
- All outputs registered; mem_addr/mem_wdata hold last value outside ACCESS (don't-care for memory, but stable).

## Timing
- Reset (rst low, async): state = IDLE, prio = 0, grant = 0, core_ack = host_ack = 0, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, core_rdata = host_rdata = 0. Effective immediately, not on clock edge.
- Reset mid-transaction: strobe and ack drop immediately, transaction abandoned (a write may or may not have reached memory if reset falls during ACCESS); after rst rises, pending reqs re-arbitrate from IDLE with prio = core.
- Latency: req seen in IDLE at cycle 0 -> ACCESS cycle 1 -> CAPTURE cycle 2 -> ack in cycle 3. Same for reads and writes.
- Throughput: one transaction per 4 cycles; continuously requesting ports alternate core, host, core, host...
- grant asserted cycles 1-3 of each transaction, 0 in IDLE.
- Single continuous requester, no competition: back-to-back transactions every 4 cycles, ack at cycles 3, 7, 11...

## Test plan
- Reset: hold rst low 3 cycles with both reqs high -> all outputs 0, no mem strobe; release -> core wins first (grant = 01 in next cycle).
- Core read: memory word 7 = 0x0000000E, core_req/core_we=0/core_addr=7 in IDLE -> mem_read high exactly one cycle (cycle 1, mem_addr=7), core_ack in cycle 3 with core_rdata = 0x0000000E; host_rdata unchanged.
- Host write then core read: host writes 0x0000000D to address 1, then core reads 1 -> mem_write one cycle with mem_wdata=0x0000000D, host_ack at cycle 3; core read returns 0x0000000D.
- Contention: both reqs held high for 16 cycles -> acks in order core, host, core, host at cycles 3, 7, 11, 15; never both acks or both grant bits high.
- Write preserves rdata: core read returns 0x7, then core write to another address -> core_rdata stays 0x7 after write ack.
- Reset mid-op: drop rst during CAPTURE of a core read -> mem strobes, ack and grant 0 immediately, no core_ack; after release with core_req still high, full read completes 3 cycles later with correct data.
